// File: rtl/exception_commit_unit_if.sv
// Commit-side event handshake, CP0 access bundle and fetch redirect signals
// shared between the exception commit unit and its surroundings.
interface exception_commit_unit_if;
    logic        commit_valid;
    logic        commit_ready;
    logic        commit_exc;
    logic        commit_eret;
    logic [4:0]  commit_exc_code;
    logic [31:0] commit_pc;
    logic        commit_bd;
    logic        commit_badv_valid;
    logic [31:0] commit_badvaddr;

    logic [31:0] cp0_status;
    logic [31:0] cp0_cause;
    logic [31:0] cp0_epc;
    logic [31:0] cp0_ebase;
    logic [4:0]  cp0_addr;
    logic [2:0]  cp0_sel;
    logic [31:0] cp0_wdata;
    logic        cp0_we;
    logic [31:0] cp0_rdata;

    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    // The environment side: commit stage, CP0 register file and fetch
    modport master (
        output commit_valid, commit_exc, commit_eret, commit_exc_code, commit_pc,
               commit_bd, commit_badv_valid, commit_badvaddr,
               cp0_status, cp0_cause, cp0_epc, cp0_ebase, cp0_rdata,
        input  commit_ready, cp0_addr, cp0_sel, cp0_wdata, cp0_we,
               flush, redirect_valid, redirect_pc
    );

    modport slave (
        input  commit_valid, commit_exc, commit_eret, commit_exc_code, commit_pc,
               commit_bd, commit_badv_valid, commit_badvaddr,
               cp0_status, cp0_cause, cp0_epc, cp0_ebase, cp0_rdata,
        output commit_ready, cp0_addr, cp0_sel, cp0_wdata, cp0_we,
               flush, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/exception_commit_unit.sv
// Serialises the CP0 side effects of an exception or ERET over the single CP0
// write port, then flushes the pipeline and redirects fetch.
module exception_commit_unit #(
    parameter logic [31:0] RESET_VECTOR_EXC = 32'hBFC00380,
    parameter logic [31:0] EXC_OFFSET       = 32'h00000180
) (
    input  logic                   clk,
    input  logic                   rst,
    exception_commit_unit_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, WR_BADV, WR_EPC, WR_CAUSE, WR_STATUS, ER_READ, ER_STATUS, REDIRECT
    } state_t;

    state_t state, state_n;

    logic        bd_q;
    logic [4:0]  code_q;
    logic [31:0] pc_q, status_q, cause_q, ebase_q, target_q;

    logic        accept;
    logic        bd_s;
    logic [31:0] pc_s, status_s;
    logic        cause_bd;

    logic        we_n, flush_n, redirect_valid_n;
    logic [4:0]  addr_n;
    logic [31:0] wdata_n, redirect_pc_n;

    assign accept           = bus.commit_valid && (state == IDLE);
    assign bus.commit_ready = (state == IDLE);
    assign bus.cp0_sel      = 3'd0;

    // Outputs are computed for the state being entered, so the first write
    // after accept must look at the live inputs rather than the snapshots.
    assign bd_s     = (state == IDLE) ? bus.commit_bd     : bd_q;
    assign pc_s     = (state == IDLE) ? bus.commit_pc     : pc_q;
    assign status_s = (state == IDLE) ? bus.cp0_status    : status_q;
    assign cause_bd = status_q[1] ? cause_q[31] : bd_q;

    // Event and CP0 snapshots taken at accept; ERET target latched from the read cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bd_q     <= 1'b0;
            code_q   <= 5'd0;
            pc_q     <= 32'd0;
            status_q <= 32'd0;
            cause_q  <= 32'd0;
            ebase_q  <= 32'd0;
            target_q <= 32'd0;
        end else begin
            if (accept) begin
                bd_q     <= bus.commit_bd;
                code_q   <= bus.commit_exc_code;
                pc_q     <= bus.commit_pc;
                status_q <= bus.cp0_status;
                cause_q  <= bus.cp0_cause;
                ebase_q  <= bus.cp0_ebase & 32'hFFFFF000;
            end
            if (state == ER_READ)
                target_q <= status_q[2] ? bus.cp0_rdata : bus.cp0_epc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            bus.cp0_we         <= 1'b0;
            bus.cp0_addr       <= 5'd0;
            bus.cp0_wdata      <= 32'd0;
            bus.flush          <= 1'b0;
            bus.redirect_valid <= 1'b0;
            bus.redirect_pc    <= 32'd0;
        end else begin
            state              <= state_n;
            bus.cp0_we         <= we_n;
            bus.cp0_addr       <= addr_n;
            bus.cp0_wdata      <= wdata_n;
            bus.flush          <= flush_n;
            bus.redirect_valid <= redirect_valid_n;
            bus.redirect_pc    <= redirect_pc_n;
        end
    end

    always_comb begin
        state_n          = state;
        we_n             = 1'b0;
        addr_n           = 5'd0;
        wdata_n          = 32'd0;
        flush_n          = 1'b0;
        redirect_valid_n = 1'b0;
        redirect_pc_n    = 32'd0;

        case (state)
            IDLE: begin
                // An exception takes priority over a simultaneous ERET
                if (accept && bus.commit_exc)
                    state_n = bus.commit_badv_valid ? WR_BADV : WR_EPC;
                else if (accept && bus.commit_eret)
                    state_n = ER_READ;
            end
            WR_BADV:   state_n = WR_EPC;
            WR_EPC:    state_n = WR_CAUSE;
            WR_CAUSE:  state_n = WR_STATUS;
            WR_STATUS: state_n = REDIRECT;
            ER_READ:   state_n = ER_STATUS;
            ER_STATUS: state_n = REDIRECT;
            REDIRECT:  state_n = IDLE;
            default:   state_n = IDLE;
        endcase

        case (state_n)
            WR_BADV: begin
                we_n    = 1'b1;
                addr_n  = 5'd8;
                wdata_n = bus.commit_badvaddr;
            end
            WR_EPC: begin
                addr_n = 5'd14;
                if (!status_s[1]) begin
                    we_n    = 1'b1;
                    wdata_n = bd_s ? pc_s - 32'd4 : pc_s;
                end
            end
            WR_CAUSE: begin
                we_n    = 1'b1;
                addr_n  = 5'd13;
                wdata_n = (cause_q & ~32'h8000007C) | {cause_bd, 31'd0} | {25'd0, code_q, 2'b00};
            end
            WR_STATUS: begin
                we_n    = 1'b1;
                addr_n  = 5'd12;
                wdata_n = status_q | 32'h2;
            end
            ER_READ: begin
                addr_n = status_s[2] ? 5'd30 : 5'd14;
            end
            ER_STATUS: begin
                we_n    = 1'b1;
                addr_n  = 5'd12;
                wdata_n = status_q[2] ? (status_q & ~32'h4) : (status_q & ~32'h2);
            end
            REDIRECT: begin
                flush_n          = 1'b1;
                redirect_valid_n = 1'b1;
                if (state == ER_STATUS)
                    redirect_pc_n = target_q;
                else
                    redirect_pc_n = status_q[22] ? RESET_VECTOR_EXC : ebase_q + EXC_OFFSET;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_exception_commit_unit.sv
// Drives exception/ERET events into the commit unit with a small CP0 register
// file model around it, and compares the write sequence and redirect against a reference.
module tb_exception_commit_unit;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    exception_commit_unit_if bus ();

    exception_commit_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // CP0 registers by number; EBase is kept in slot 15
    logic [31:0] regs [32];

    assign bus.cp0_status = regs[12];
    assign bus.cp0_cause  = regs[13];
    assign bus.cp0_epc    = regs[14];
    assign bus.cp0_ebase  = regs[15];
    assign bus.cp0_rdata  = regs[bus.cp0_addr];

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        int          off;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         got_q[$];
    int          exp_lat;
    logic [31:0] exp_rpc;
    logic [31:0] last_rpc;

    int checks   = 0;
    int failures = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
        checks++;
        if (got !== expected) begin
            failures++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, expected);
        end
    endtask

    task automatic pushExp(input logic [4:0] a, input logic [31:0] d, input int o);
        wr_t w;
        w.addr = a;
        w.data = d;
        w.off  = o;
        exp_q.push_back(w);
    endtask

    // Reference: architectural effect of one event, step by step from accept
    task automatic buildExpected(input logic exc, input logic [4:0] code, input logic [31:0] pc,
                                 input logic bd, input logic bv, input logic [31:0] badv);
        logic [31:0] st, ca, eb;
        logic        bdbit;
        int          t;
        st = regs[12];
        ca = regs[13];
        eb = regs[15];
        exp_q.delete();
        if (exc) begin
            t = 1;
            if (bv) begin
                pushExp(5'd8, badv, t);
                t++;
            end
            if (!st[1]) pushExp(5'd14, bd ? pc - 32'd4 : pc, t);
            t++;
            bdbit = st[1] ? ca[31] : bd;
            pushExp(5'd13, (ca & ~32'h8000007C) | (32'(bdbit) << 31) | (32'(code) << 2), t);
            t++;
            pushExp(5'd12, st | 32'h2, t);
            t++;
            exp_lat = t;
            exp_rpc = st[22] ? 32'hBFC00380 : (eb & 32'hFFFFF000) + 32'h180;
        end else begin
            pushExp(5'd12, st[2] ? (st & ~32'h4) : (st & ~32'h2), 2);
            exp_lat = 3;
            exp_rpc = st[2] ? regs[30] : regs[14];
        end
    endtask

    task automatic applyStimulus(input logic exc, input logic eret, input logic [4:0] code,
                                 input logic [31:0] pc, input logic bd, input logic bv,
                                 input logic [31:0] badv, input bit pulse_busy);
        int redirects = 0, flushes = 0, rd_off = 0, fl_off = 0, sel_bad = 0, ready_bad = 0;
        buildExpected(exc, code, pc, bd, bv, badv);
        got_q.delete();
        @(negedge clk);
        checkOutput("ready_before", 32'(bus.commit_ready), 32'd1);
        bus.commit_valid      = 1'b1;
        bus.commit_exc        = exc;
        bus.commit_eret       = eret;
        bus.commit_exc_code   = code;
        bus.commit_pc         = pc;
        bus.commit_bd         = bd;
        bus.commit_badv_valid = bv;
        bus.commit_badvaddr   = badv;
        @(posedge clk);
        #1;
        bus.commit_valid = 1'b0;
        for (int k = 1; k <= exp_lat + 3; k++) begin
            @(negedge clk);
            if (bus.cp0_we) begin
                wr_t w;
                w.addr = bus.cp0_addr;
                w.data = bus.cp0_wdata;
                w.off  = k;
                got_q.push_back(w);
                regs[bus.cp0_addr] = bus.cp0_wdata;
            end
            if (bus.redirect_valid) begin
                redirects++;
                rd_off   = k;
                last_rpc = bus.redirect_pc;
            end
            if (bus.flush) begin
                flushes++;
                fl_off = k;
            end
            if (bus.cp0_sel != 3'd0) sel_bad++;
            if (k <= exp_lat && bus.commit_ready) ready_bad++;
            if (pulse_busy && k == 1) begin
                bus.commit_valid      = 1'b1;
                bus.commit_exc        = 1'b1;
                bus.commit_badv_valid = 1'b1;
                bus.commit_badvaddr   = 32'hDEAD0000;
            end
            if (pulse_busy && k == 2) bus.commit_valid = 1'b0;
        end
        checkOutput("num_writes", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checkOutput($sformatf("wr%0d_addr", i), 32'(got_q[i].addr), 32'(exp_q[i].addr));
            checkOutput($sformatf("wr%0d_data", i), got_q[i].data, exp_q[i].data);
            checkOutput($sformatf("wr%0d_cycle", i), 32'(got_q[i].off), 32'(exp_q[i].off));
        end
        checkOutput("redirect_count", 32'(redirects), 32'd1);
        checkOutput("redirect_cycle", 32'(rd_off), 32'(exp_lat));
        checkOutput("redirect_pc", last_rpc, exp_rpc);
        checkOutput("flush_count", 32'(flushes), 32'd1);
        checkOutput("flush_cycle", 32'(fl_off), 32'(exp_lat));
        checkOutput("sel_zero", 32'(sel_bad), 32'd0);
        checkOutput("ready_busy", 32'(ready_bad), 32'd0);
    endtask

    task automatic resetMidSequence();
        int writes = 0, redirects = 0;
        regs[12] = 32'h00400000;
        regs[13] = 32'h0;
        @(negedge clk);
        bus.commit_valid      = 1'b1;
        bus.commit_exc        = 1'b1;
        bus.commit_eret       = 1'b0;
        bus.commit_exc_code   = 5'd10;
        bus.commit_pc         = 32'h80004000;
        bus.commit_bd         = 1'b0;
        bus.commit_badv_valid = 1'b0;
        @(posedge clk);
        #1;
        bus.commit_valid = 1'b0;
        @(negedge clk);
        checkOutput("rstmid_epc_addr", 32'(bus.cp0_addr), 32'd14);
        @(posedge clk);
        #1;
        checkOutput("rstmid_cause_we", 32'(bus.cp0_we), 32'd1);
        checkOutput("rstmid_cause_addr", 32'(bus.cp0_addr), 32'd13);
        rst = 1'b1;
        #1;
        checkOutput("rstmid_we", 32'(bus.cp0_we), 32'd0);
        checkOutput("rstmid_addr", 32'(bus.cp0_addr), 32'd0);
        checkOutput("rstmid_wdata", bus.cp0_wdata, 32'd0);
        checkOutput("rstmid_flush", 32'(bus.flush), 32'd0);
        checkOutput("rstmid_redirect", 32'(bus.redirect_valid), 32'd0);
        checkOutput("rstmid_rpc", bus.redirect_pc, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.cp0_we) writes++;
            if (bus.redirect_valid || bus.flush) redirects++;
        end
        checkOutput("rstmid_no_writes", 32'(writes), 32'd0);
        checkOutput("rstmid_no_redirect", 32'(redirects), 32'd0);
        checkOutput("rstmid_ready", 32'(bus.commit_ready), 32'd1);
    endtask

    initial begin
        logic e, r;
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        rst                   = 1'b1;
        bus.commit_valid      = 1'b0;
        bus.commit_exc        = 1'b0;
        bus.commit_eret       = 1'b0;
        bus.commit_exc_code   = 5'd0;
        bus.commit_pc         = 32'd0;
        bus.commit_bd         = 1'b0;
        bus.commit_badv_valid = 1'b0;
        bus.commit_badvaddr   = 32'd0;
        last_rpc              = 32'd0;
        repeat (3) @(negedge clk);
        checkOutput("reset_we", 32'(bus.cp0_we), 32'd0);
        checkOutput("reset_addr", 32'(bus.cp0_addr), 32'd0);
        checkOutput("reset_sel", 32'(bus.cp0_sel), 32'd0);
        checkOutput("reset_wdata", bus.cp0_wdata, 32'd0);
        checkOutput("reset_flush", 32'(bus.flush), 32'd0);
        checkOutput("reset_redirect", 32'(bus.redirect_valid), 32'd0);
        checkOutput("reset_rpc", bus.redirect_pc, 32'd0);
        checkOutput("reset_ready", 32'(bus.commit_ready), 32'd1);
        rst = 1'b0;

        // Syscall under BEV=1
        regs[12] = 32'h10400004;
        regs[13] = 32'h0;
        applyStimulus(1'b1, 1'b0, 5'd8, 32'h80001000, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("syscall_vector", last_rpc, 32'hBFC00380);
        checkOutput("syscall_status", regs[12], 32'h10400006);

        // AdEL in a delay slot, BEV=0
        regs[12] = 32'h0;
        regs[13] = 32'h0;
        regs[15] = 32'h80000000;
        applyStimulus(1'b1, 1'b0, 5'd4, 32'h80002004, 1'b1, 1'b1, 32'h00000003, 1'b0);
        checkOutput("adel_vector", last_rpc, 32'h80000180);
        checkOutput("adel_cause", regs[13], 32'h80000010);

        // Nested exception keeps EPC and the old Cause.BD
        regs[12] = 32'h00000002;
        regs[13] = 32'h0;
        regs[14] = 32'h00001234;
        applyStimulus(1'b1, 1'b0, 5'd12, 32'h80005000, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("nested_epc_kept", regs[14], 32'h00001234);

        // ERET from EXL, then from ERL
        regs[12] = 32'h0000FF03;
        regs[14] = 32'h80003000;
        applyStimulus(1'b0, 1'b1, 5'd0, 32'h80006000, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("eret_exl_status", regs[12], 32'h0000FF01);
        checkOutput("eret_exl_target", last_rpc, 32'h80003000);
        regs[12] = 32'h0000FF07;
        regs[30] = 32'hBFC00000;
        applyStimulus(1'b0, 1'b1, 5'd0, 32'h80006000, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("eret_erl_status", regs[12], 32'h0000FF03);
        checkOutput("eret_erl_target", last_rpc, 32'hBFC00000);

        // Exception and ERET together, with a commit pulse while busy
        regs[12] = 32'h00400000;
        applyStimulus(1'b1, 1'b1, 5'd13, 32'h80007000, 1'b0, 1'b0, 32'h0, 1'b1);

        // EPC wraps when pc=0 in a delay slot
        regs[12] = 32'h0;
        applyStimulus(1'b1, 1'b0, 5'd6, 32'h00000000, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("epc_wrap", regs[14], 32'hFFFFFFFC);

        resetMidSequence();
        regs[12] = 32'h0;
        applyStimulus(1'b1, 1'b0, 5'd9, 32'h80008000, 1'b0, 1'b1, 32'h12345678, 1'b0);

        for (int n = 0; n < 40; n++) begin
            regs[12] = $urandom;
            regs[13] = $urandom;
            regs[14] = $urandom;
            regs[15] = $urandom;
            regs[30] = $urandom;
            e = 1'($urandom_range(0, 1));
            r = e ? 1'($urandom_range(0, 1)) : 1'b1;
            applyStimulus(e, r, 5'($urandom), $urandom, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), $urandom, bit'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/exception_commit_unit.md
Name: exception_commit_unit

Overview:
- Sits between the commit stage and the CP0 register file; it is the sole driver of the CP0 exception write port.
- Accepts one exception or ERET event from commit and serialises the architectural CP0 updates (BadVAddr, EPC, Cause, Status) over the single-write-per-cycle port.
- Then issues a pipeline flush and a PC redirect to the exception vector or the return address.

Parameters:
- RESET_VECTOR_EXC, 32'hBFC00380, vector used when Status.BEV=1.
- EXC_OFFSET, 32'h00000180, offset added to EBase[31:12]<<12 when BEV=0.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- commit_valid  in  1  commit presents an event.
- commit_ready  out  1  unit idle, can accept.
- commit_exc  in  1  event is an exception.
- commit_eret  in  1  event is ERET.
- commit_exc_code  in  5  ExcCode.
- commit_pc  in  32  PC of faulting/ERET instruction.
- commit_bd  in  1  instruction is in a delay slot.
- commit_badv_valid  in  1  BadVAddr must be written.
- commit_badvaddr  in  32  faulting address.
- cp0_status  in  32  current Status (from CP0 status bundle).
- cp0_cause  in  32  current Cause.
- cp0_epc  in  32  current EPC.
- cp0_ebase  in  32  current EBase.
- cp0_addr  out  5  CP0 register number.
- cp0_sel  out  3  CP0 select.
- cp0_wdata  out  32  write data.
- cp0_we  out  1  write enable.
- cp0_rdata  in  32  combinational read data for cp0_addr/cp0_sel.
- flush  out  1  one-cycle pipeline flush.
- redirect_valid  out  1  one-cycle redirect strobe.
- redirect_pc  out  32  redirect target.

Behaviour:
- Reset (async): state=IDLE; cp0_we=0, cp0_addr=0, cp0_sel=0, cp0_wdata=0, flush=0, redirect_valid=0, redirect_pc=0.
- commit_ready=1 only in IDLE. An event is accepted on a cycle with commit_valid && commit_ready.
- If commit_exc and commit_eret are both set, the exception wins and ERET is ignored.
- At accept, the unit captures the following into holding registers:
  - the event inputs;
  - cp0_status/cp0_cause/cp0_ebase as snapshots;
  - exl_snap=cp0_status[1] and erl_snap=cp0_status[2].
- Exception FSM:
  - IDLE → WR_BADV if badv_valid, else → WR_EPC.
  - WR_BADV: cp0_addr=8, we=1, wdata=badvaddr → WR_EPC.
  - WR_EPC: if exl_snap=0, addr=14, we=1, wdata = bd ? pc-32'd4 : pc; if exl_snap=1, we=0 (EPC preserved) → WR_CAUSE.
  - WR_CAUSE: addr=13, we=1. wdata = (cause_snap & ~32'h8000007C) | (BD<<31) | (code<<2).
    - BD = exl_snap ? cause_snap[31] : bd.
    - → WR_STATUS.
  - WR_STATUS: addr=12, we=1, wdata=status_snap | 32'h2 → REDIRECT.
  - REDIRECT: flush=1, redirect_valid=1 → IDLE.
    - redirect_pc = status_snap[22] ? RESET_VECTOR_EXC : {ebase_snap[31:12],12'h0}+EXC_OFFSET.
- ERET FSM:
  - IDLE → ER_READ.
  - ER_READ: addr = erl_snap ? 30 : 14, sel=0, we=0. rdata is latched as the return target; if erl_snap=0, cp0_epc is used instead (equal value) → ER_STATUS.
  - ER_STATUS: addr=12, we=1, wdata = erl_snap ? status_snap & ~32'h4 : status_snap & ~32'h2 → REDIRECT.
  - REDIRECT: flush=1, redirect_valid=1, redirect_pc=target → IDLE.
- Latency: exception 5 cycles accept→redirect with BadVAddr, 4 without; ERET 3 cycles.
- All outputs are registered. cp0_we is 0 in every non-write state, and cp0_sel=0 in every state.
- commit_valid during busy states is ignored (not accepted, not buffered). Commit must hold the event until ready.
- PC arithmetic is 32-bit modulo: pc=0 with bd gives EPC=32'hFFFFFFFC.
- rst asserted mid-sequence aborts immediately with no further CP0 writes and no redirect. A partial update already written is not rolled back.

Test Plan:
- Syscall (code 8), pc=32'h80001000, bd=0, Status=32'h10400004 (BEV=1), Cause=0 → in order: EPC write 32'h80001000, Cause write 32'h00000020, Status write 32'h10400006; redirect_pc=32'hBFC00380; flush and redirect high exactly one cycle.
- AdEL (code 4), bd=1, pc=32'h80002004, badv=32'h00000003, BEV=0, EBase=32'h80000000 → BadVAddr write 3, EPC write 32'h80002000, Cause write 32'h80000010, redirect_pc=32'h80000180, 5 cycles after accept.
- Nested exception with Status.EXL=1, EPC=32'h1234 → no EPC write (we=0 in WR_EPC), Cause BD taken from old Cause, EPC register unchanged.
- ERET with EXL=1, ERL=0, EPC=32'h80003000, Status=32'h0000FF03 → Status write 32'h0000FF01, redirect_pc=32'h80003000. With ERL=1 and ErrorEPC=32'hBFC00000 → Status write clears bit2, redirect_pc=32'hBFC00000.
- commit_exc=1 and commit_eret=1 simultaneously → exception sequence only; commit_valid pulsed while busy → no second accept, and commit_ready stays 0 until IDLE.
- Assert rst during WR_CAUSE → all outputs 0 in the same cycle, no Status write, no redirect; next event after rst deasserts is processed normally.
